verinject_lockstep_checker: RTL and testbench

Synthesizable lockstep comparator for fault-injection runs. It compares the outputs of a golden design instance against its `__injected` twin on a parameterised number of channels each cycle. Each mismatch is timestamped with the injector's `cycle_number` and queued in an event FIFO for draining by a monitor or host. This replaces per-signal `$display` comparison in benches and allows injection campaigns to run on FPGA.

---
 rtl/verinject_lockstep_checker.sv | 185 ++++++++++++++++++
 tb/tb_verinject_lockstep_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verinject_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module   : verinject_lockstep_checker
// Brief    : Lockstep comparator between a golden design instance and its
//            injected twin. Per-cycle mismatches are timestamped with the
//            injector cycle number and queued in an event FIFO, alongside a
//            saturating mismatch-cycle counter and first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
module verinject_lockstep_checker #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 32,
  parameter int CYCLE_WIDTH = 48,
  parameter int LOG_DEPTH   = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [CYCLE_WIDTH-1:0]       cycle_number,
  input  logic [CHANNELS-1:0]          channel_mask,
  input  logic [CHANNELS*WIDTH-1:0]    golden,
  input  logic [CHANNELS*WIDTH-1:0]    injected,
  output logic                         event_valid,
  input  logic                         event_ready,
  output logic [CYCLE_WIDTH-1:0]       event_cycle,
  output logic [CHANNELS-1:0]          event_channels,
  output logic [WIDTH-1:0]             event_xor,
  output logic [COUNT_WIDTH-1:0]       mismatch_cycles,
  output logic                         first_valid,
  output logic [CYCLE_WIDTH-1:0]       first_cycle,
  output logic                         overflow
);

  localparam int c_DEPTH = 1 << LOG_DEPTH;

  // --------------------------------------------------------------------------
  // Stage 0 comparison: per-channel difference and masked hit bitmap
  // --------------------------------------------------------------------------
  logic [CHANNELS*WIDTH-1:0] w_diff;
  logic [CHANNELS-1:0]       w_hit;
  logic [WIDTH-1:0]          w_first_xor;
  logic                      w_found;

  assign w_diff = golden ^ injected;

  genvar g_k;
  generate
    for (g_k = 0; g_k < CHANNELS; g_k++) begin : g_hit
      assign w_hit[g_k] = channel_mask[g_k] & (|w_diff[g_k*WIDTH +: WIDTH]);
    end
  endgenerate

  // Priority encoder, LSB first: pick the XOR of the lowest mismatching channel
  always_comb begin
    w_first_xor = '0;
    w_found     = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_hit[k] && !w_found) begin
        w_first_xor = w_diff[k*WIDTH +: WIDTH];
        w_found     = 1'b1;
      end
    end
  end

  logic [CYCLE_WIDTH-1:0] r_s0_cycle;
  logic [CHANNELS-1:0]    r_s0_hit;
  logic [WIDTH-1:0]       r_s0_xor;

  // Stage 0 register; a zero bitmap means "no event" so disable/clear only need to zero it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_cycle <= '0;
      r_s0_hit   <= '0;
      r_s0_xor   <= '0;
    end else if (clear || !enable) begin
      r_s0_hit   <= '0;
    end else begin
      r_s0_cycle <= cycle_number;
      r_s0_hit   <= w_hit;
      r_s0_xor   <= w_first_xor;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: event FIFO with LOG_DEPTH+1-bit pointers
  // --------------------------------------------------------------------------
  logic [CYCLE_WIDTH-1:0] r_mem_cycle [c_DEPTH];
  logic [CHANNELS-1:0]    r_mem_chan  [c_DEPTH];
  logic [WIDTH-1:0]       r_mem_xor   [c_DEPTH];
  logic [LOG_DEPTH:0]     r_wr_ptr;
  logic [LOG_DEPTH:0]     r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_event;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) &&
                   (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]);
  assign w_event = |r_s0_hit;
  assign w_pop   = event_ready && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;

  // Event storage; written only on an accepted push
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem_cycle[i] <= '0;
        r_mem_chan[i]  <= '0;
        r_mem_xor[i]   <= '0;
      end
    end else if (!clear && w_push) begin
      r_mem_cycle[r_wr_ptr[LOG_DEPTH-1:0]] <= r_s0_cycle;
      r_mem_chan[r_wr_ptr[LOG_DEPTH-1:0]]  <= r_s0_hit;
      r_mem_xor[r_wr_ptr[LOG_DEPTH-1:0]]   <= r_s0_xor;
    end
  end

  // FIFO pointers; clear empties the queue and wins over push/pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics: saturating counter, first-mismatch capture, sticky overflow
  // --------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_first_valid;
  logic [CYCLE_WIDTH-1:0] r_first_cycle;
  logic                   r_overflow;

  // Statistics update on every mismatching cycle, whether or not the event was queued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count       <= '0;
      r_first_valid <= 1'b0;
      r_first_cycle <= '0;
      r_overflow    <= 1'b0;
    end else if (clear) begin
      r_count       <= '0;
      r_first_valid <= 1'b0;
      r_first_cycle <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_event && (r_count != {COUNT_WIDTH{1'b1}})) begin
        r_count <= r_count + 1'b1;
      end
      if (w_event && !r_first_valid) begin
        r_first_valid <= 1'b1;
        r_first_cycle <= r_s0_cycle;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head of queue is read straight from storage
  assign event_valid     = !w_empty;
  assign event_cycle     = r_mem_cycle[r_rd_ptr[LOG_DEPTH-1:0]];
  assign event_channels  = r_mem_chan[r_rd_ptr[LOG_DEPTH-1:0]];
  assign event_xor       = r_mem_xor[r_rd_ptr[LOG_DEPTH-1:0]];
  assign mismatch_cycles = r_count;
  assign first_valid     = r_first_valid;
  assign first_cycle     = r_first_cycle;
  assign overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_verinject_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_verinject_lockstep_checker
// Brief    : Directed self-checking bench for the lockstep checker
//            (CHANNELS=2, WIDTH=32, LOG_DEPTH=3, COUNT_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_verinject_lockstep_checker;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [47:0] cycle_number;
  logic [1:0]  channel_mask;
  logic [63:0] golden;
  logic [63:0] injected;
  logic        event_valid;
  logic        event_ready;
  logic [47:0] event_cycle;
  logic [1:0]  event_channels;
  logic [31:0] event_xor;
  logic [3:0]  mismatch_cycles;
  logic        first_valid;
  logic [47:0] first_cycle;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  verinject_lockstep_checker #(
    .CHANNELS   (2),
    .WIDTH      (32),
    .CYCLE_WIDTH(48),
    .LOG_DEPTH  (3),
    .COUNT_WIDTH(4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear          (clear),
    .cycle_number   (cycle_number),
    .channel_mask   (channel_mask),
    .golden         (golden),
    .injected       (injected),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_cycle    (event_cycle),
    .event_channels (event_channels),
    .event_xor      (event_xor),
    .mismatch_cycles(mismatch_cycles),
    .first_valid    (first_valid),
    .first_cycle    (first_cycle),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    golden   = 64'hA5A5_0000_1234_5678;
    injected = golden;
  endtask

  task automatic set_mm(input logic [47:0] cyc, input logic [31:0] x0, input logic [31:0] x1);
    cycle_number = cyc;
    golden       = 64'hA5A5_0000_1234_5678;
    injected     = golden ^ {x1, x0};
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic pop_one();
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", event_valid); end
    total++; if (mismatch_cycles !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", mismatch_cycles); end
    total++; if (first_valid !== 1'b0 || first_cycle !== 48'd0) begin bad++; $display("FAIL rst_first got=%0b/%0d exp=0/0", first_valid, first_cycle); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
    total++; if (event_cycle !== 48'd0 || event_channels !== 2'b00 || event_xor !== 32'd0) begin
      bad++; $display("FAIL rst_event got=%0d/%b/%h exp=0/00/0", event_cycle, event_channels, event_xor);
    end
  endtask

  task automatic test_identical();
    channel_mask = 2'b11;
    for (int i = 0; i < 100; i++) begin
      cycle_number = 48'(i);
      golden       = {$urandom, $urandom};
      injected     = golden;
      step();
    end
    set_idle();
    step();
    total++; if (event_valid !== 1'b0 || mismatch_cycles !== 4'd0 || first_valid !== 1'b0) begin
      bad++; $display("FAIL identical got valid=%0b cnt=%0d first=%0b exp 0/0/0", event_valid, mismatch_cycles, first_valid);
    end
  endtask

  task automatic test_single();
    do_clear();
    set_mm(48'd37, 32'h0, 32'h0000_0010);
    step();
    set_idle();
    step();
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd37) begin bad++; $display("FAIL single_cycle got=%0b/%0d exp=1/37", event_valid, event_cycle); end
    total++; if (event_channels !== 2'b10 || event_xor !== 32'h0000_0010) begin bad++; $display("FAIL single_map got=%b/%h exp=10/00000010", event_channels, event_xor); end
    total++; if (first_valid !== 1'b1 || first_cycle !== 48'd37 || mismatch_cycles !== 4'd1) begin
      bad++; $display("FAIL single_stats got=%0b/%0d/%0d exp=1/37/1", first_valid, first_cycle, mismatch_cycles);
    end
    pop_one();
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%0b exp=0", event_valid); end
  endtask

  task automatic test_multi();
    do_clear();
    set_mm(48'd5, 32'h1, 32'h8000_0000);
    step(); set_idle(); step();
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd5 || event_channels !== 2'b11 || event_xor !== 32'h1) begin
      bad++; $display("FAIL multi_both got=%0b/%0d/%b/%h exp=1/5/11/00000001", event_valid, event_cycle, event_channels, event_xor);
    end
    pop_one();
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL multi_one_event got=%0b exp=0", event_valid); end
    channel_mask = 2'b01;
    set_mm(48'd6, 32'h1, 32'h8000_0000);
    step(); set_idle(); step();
    total++; if (event_channels !== 2'b01 || event_xor !== 32'h1) begin bad++; $display("FAIL multi_mask01 got=%b/%h exp=01/00000001", event_channels, event_xor); end
    pop_one();
    channel_mask = 2'b10;
    set_mm(48'd7, 32'h1, 32'h8000_0000);
    step(); set_idle(); step();
    total++; if (event_channels !== 2'b10 || event_xor !== 32'h8000_0000) begin bad++; $display("FAIL multi_mask10 got=%b/%h exp=10/80000000", event_channels, event_xor); end
    pop_one();
    channel_mask = 2'b00;
    set_mm(48'd8, 32'h1, 32'h8000_0000);
    step(); set_idle(); step();
    total++; if (event_valid !== 1'b0 || mismatch_cycles !== 4'd3) begin bad++; $display("FAIL multi_mask00 got=%0b/%0d exp=0/3", event_valid, mismatch_cycles); end
    channel_mask = 2'b11;
  endtask

  task automatic test_enable();
    do_clear();
    enable = 1'b0;
    set_mm(48'd9, 32'h4, 32'h0);
    step();
    enable = 1'b1; set_idle(); step();
    total++; if (event_valid !== 1'b0 || mismatch_cycles !== 4'd0) begin bad++; $display("FAIL enable_off got=%0b/%0d exp=0/0", event_valid, mismatch_cycles); end
    set_mm(48'd10, 32'h4, 32'h0);
    step();
    enable = 1'b0; set_idle(); step();
    enable = 1'b1;
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd10) begin bad++; $display("FAIL enable_inflight got=%0b/%0d exp=1/10", event_valid, event_cycle); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    do_clear();
    event_ready = 1'b1;
    set_mm(48'd50, 32'h2, 32'h0); step();
    set_mm(48'd51, 32'h2, 32'h0); step();
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd50) begin bad++; $display("FAIL b2b_0 got=%0b/%0d exp=1/50", event_valid, event_cycle); end
    set_mm(48'd52, 32'h2, 32'h0); step();
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd51) begin bad++; $display("FAIL b2b_1 got=%0b/%0d exp=1/51", event_valid, event_cycle); end
    set_idle(); step();
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd52) begin bad++; $display("FAIL b2b_2 got=%0b/%0d exp=1/52", event_valid, event_cycle); end
    step();
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b exp=0", event_valid); end
    event_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    logic [47:0] exp_cyc;
    do_clear();
    event_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_mm(48'(100 + i), 32'(1) << i, 32'h0);
      step();
    end
    set_idle(); step();
    total++; if (overflow !== 1'b1 || mismatch_cycles !== 4'd10 || first_cycle !== 48'd100) begin
      bad++; $display("FAIL ovf_stats got=%0b/%0d/%0d exp=1/10/100", overflow, mismatch_cycles, first_cycle);
    end
    total++; if (event_valid !== 1'b1 || event_cycle !== 48'd100 || event_xor !== 32'h1) begin
      bad++; $display("FAIL ovf_head got=%0b/%0d/%h exp=1/100/00000001", event_valid, event_cycle, event_xor);
    end
    set_mm(48'd200, 32'h3, 32'h0); step();
    set_idle(); event_ready = 1'b1; step(); event_ready = 1'b0;
    total++; if (event_cycle !== 48'd101 || mismatch_cycles !== 4'd11) begin bad++; $display("FAIL ovf_pushpop got=%0d/%0d exp=101/11", event_cycle, mismatch_cycles); end
    n = 0;
    event_ready = 1'b1;
    while (event_valid === 1'b1 && n < 20) begin
      exp_cyc = (n < 7) ? 48'(101 + n) : 48'd200;
      total++; if (event_cycle !== exp_cyc) begin bad++; $display("FAIL ovf_drain%0d got=%0d exp=%0d", n, event_cycle, exp_cyc); end
      step();
      n++;
    end
    event_ready = 1'b0;
    total++; if (n != 8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", n); end
  endtask

  task automatic test_clear();
    // Overflow and the counter are still set from the previous scenario
    set_mm(48'd300, 32'h5, 32'h0); step();
    set_idle(); step();
    set_mm(48'd301, 32'h5, 32'h0); step();
    set_idle(); clear = 1'b1; step(); clear = 1'b0;
    step();
    total++; if (event_valid !== 1'b0 || mismatch_cycles !== 4'd0) begin bad++; $display("FAIL clear_fifo got=%0b/%0d exp=0/0", event_valid, mismatch_cycles); end
    total++; if (first_valid !== 1'b0 || first_cycle !== 48'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL clear_stats got=%0b/%0d/%0b exp=0/0/0", first_valid, first_cycle, overflow);
    end
  endtask

  task automatic test_async_reset();
    set_mm(48'd400, 32'h7, 32'h7); step();
    set_idle(); step();
    total++; if (event_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0b exp=1", event_valid); end
    reset_n = 1'b0;
    #2;
    test_reset();
    #1;
    reset_n = 1'b1;
    step();
    total++; if (event_valid !== 1'b0 || mismatch_cycles !== 4'd0) begin bad++; $display("FAIL arst_post got=%0b/%0d exp=0/0", event_valid, mismatch_cycles); end
  endtask

  task automatic test_saturation();
    do_clear();
    event_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_mm(48'(500 + i), 32'h0, 32'h100);
      step();
    end
    set_idle(); step();
    total++; if (mismatch_cycles !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", mismatch_cycles); end
    total++; if (first_cycle !== 48'd500 || overflow !== 1'b1) begin bad++; $display("FAIL sat_stats got=%0d/%0b exp=500/1", first_cycle, overflow); end
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b1;
    clear        = 1'b0;
    cycle_number = '0;
    channel_mask = 2'b11;
    event_ready  = 1'b0;
    set_idle();
    step(); step(); step();
    test_reset();
    reset_n = 1'b1;
    step();
    test_identical();
    test_single();
    test_multi();
    test_enable();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
